// File: rtl/param_queue_pkg.sv
// rtl/param_queue_pkg.sv - width helpers shared by every queue and queue RAM instance
package queue_pkg;

    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/param_queue_if.sv
// rtl/param_queue_if.sv - enqueue/dequeue ready/valid bundle for param_queue
interface param_queue_if #(
    parameter int WIDTH = 122
);
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_bits;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_bits;

    modport master (
        output enq_valid, enq_bits, deq_ready,
        input  enq_ready, deq_valid, deq_bits
    );

    modport slave (
        input  enq_valid, enq_bits, deq_ready,
        output enq_ready, deq_valid, deq_bits
    );
endinterface

// File: rtl/param_queue_ram.sv
// rtl/param_queue_ram.sv - queue storage, one clocked write port and one combinational read port
module queue_ram
    import queue_pkg::*;
#(
    parameter int  WIDTH = 122,
    parameter int  DEPTH = 2,
    localparam int AW    = ptr_w(DEPTH)
) (
    input  logic             clock,
    input  logic             W_en,
    input  logic [AW-1:0]    W_addr,
    input  logic [WIDTH-1:0] W_data,
    input  logic             R_en,
    input  logic [AW-1:0]    R_addr,
    output logic [WIDTH-1:0] R_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (W_en) begin
            mem[W_addr] <= W_data;
        end
    end

    assign R_data = R_en ? mem[R_addr] : {WIDTH{1'bx}};

endmodule

// File: rtl/param_queue.sv
// rtl/param_queue.sv - parametrised ready/valid FIFO with optional pipe/flow modes and occupancy
module param_queue
    import queue_pkg::*;
#(
    parameter int  WIDTH     = 122,
    parameter int  DEPTH     = 2,
    parameter int  PIPE      = 0,
    parameter int  FLOW      = 0,
    parameter int  AFULL_LVL = DEPTH - 1,
    localparam int CNT_W     = cnt_w(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    param_queue_if.slave     io,
    output logic [CNT_W-1:0] count,
    output logic             almost_full
);

    localparam int               PTR_W   = ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] enq_ptr;
    logic [PTR_W-1:0] deq_ptr;
    logic             maybe_full;
    logic             ptr_match;
    logic             empty;
    logic             full;
    logic             do_enq;
    logic             do_deq;
    logic             flow_thru;
    logic             enq_fire;
    logic             deq_fire;
    logic [WIDTH-1:0] ram_rdata;
    logic [CNT_W-1:0] enq_ext;
    logic [CNT_W-1:0] deq_ext;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign ptr_match = (enq_ptr == deq_ptr);
    assign empty     = ptr_match & ~maybe_full;
    assign full      = ptr_match & maybe_full;

    assign io.enq_ready = ~full | ((PIPE != 0) & io.deq_ready);
    assign io.deq_valid = ~empty | ((FLOW != 0) & io.enq_valid);
    assign io.deq_bits  = ((FLOW != 0) && empty) ? io.enq_bits : ram_rdata;

    assign do_enq = io.enq_valid & io.enq_ready;
    assign do_deq = io.deq_valid & io.deq_ready;

    // A forwarded beat bypasses storage entirely, so neither side counts as a state update.
    assign flow_thru = (FLOW != 0) & empty & do_deq;
    assign enq_fire  = do_enq & ~flow_thru;
    assign deq_fire  = do_deq & ~flow_thru;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (enq_fire) begin
                enq_ptr <= next_ptr(enq_ptr);
            end
            if (deq_fire) begin
                deq_ptr <= next_ptr(deq_ptr);
            end
            if (enq_fire != deq_fire) begin
                maybe_full <= enq_fire;
            end
        end
    end

    assign enq_ext = CNT_W'(enq_ptr);
    assign deq_ext = CNT_W'(deq_ptr);

    always_comb begin
        if (full) begin
            count = DEPTH_C;
        end else if (enq_ptr >= deq_ptr) begin
            count = enq_ext - deq_ext;
        end else begin
            count = enq_ext + DEPTH_C - deq_ext;
        end
    end

    assign almost_full = (int'(count) >= AFULL_LVL);

    queue_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock  (clock),
        .W_en   (enq_fire),
        .W_addr (enq_ptr),
        .W_data (io.enq_bits),
        .R_en   (~empty),
        .R_addr (deq_ptr),
        .R_data (ram_rdata)
    );

endmodule

// File: tb/tb_param_queue.sv
// tb/tb_param_queue.sv - directed and randomized checks of param_queue against a queue model
module tb_param_queue;

    localparam int W = 122;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // instance 0: DEPTH=2 W=122, 1: DEPTH=3, 2: DEPTH=2 PIPE, 3: DEPTH=2 FLOW
    int depth_c [N] = '{2, 3, 2, 2};
    bit pipe_c  [N] = '{0, 0, 1, 0};
    bit flow_c  [N] = '{0, 0, 0, 1};

    logic         ev  [N];
    logic         dr  [N];
    logic [W-1:0] eb  [N];
    logic         o_er [N];
    logic         o_dv [N];
    logic [W-1:0] o_db [N];
    logic [1:0]   cnt  [N];
    logic         af   [N];
    logic [1:0]   cnt0, cnt1, cnt2, cnt3;
    logic         af0, af1, af2, af3;
    logic [W-1:0] mq [N][$];

    param_queue_if #(.WIDTH(122)) if0 ();
    param_queue_if #(.WIDTH(8))   if1 ();
    param_queue_if #(.WIDTH(8))   if2 ();
    param_queue_if #(.WIDTH(8))   if3 ();

    param_queue #(.WIDTH(122), .DEPTH(2)) u_d2 (
        .clock(clock), .reset(reset), .io(if0), .count(cnt0), .almost_full(af0));
    param_queue #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .clock(clock), .reset(reset), .io(if1), .count(cnt1), .almost_full(af1));
    param_queue #(.WIDTH(8), .DEPTH(2), .PIPE(1)) u_pipe (
        .clock(clock), .reset(reset), .io(if2), .count(cnt2), .almost_full(af2));
    param_queue #(.WIDTH(8), .DEPTH(2), .FLOW(1)) u_flow (
        .clock(clock), .reset(reset), .io(if3), .count(cnt3), .almost_full(af3));

    assign if0.enq_valid = ev[0];  assign if0.deq_ready = dr[0];  assign if0.enq_bits = eb[0];
    assign if1.enq_valid = ev[1];  assign if1.deq_ready = dr[1];  assign if1.enq_bits = eb[1][7:0];
    assign if2.enq_valid = ev[2];  assign if2.deq_ready = dr[2];  assign if2.enq_bits = eb[2][7:0];
    assign if3.enq_valid = ev[3];  assign if3.deq_ready = dr[3];  assign if3.enq_bits = eb[3][7:0];

    assign o_er[0] = if0.enq_ready;  assign o_dv[0] = if0.deq_valid;  assign o_db[0] = if0.deq_bits;
    assign o_er[1] = if1.enq_ready;  assign o_dv[1] = if1.deq_valid;  assign o_db[1] = {{(W-8){1'b0}}, if1.deq_bits};
    assign o_er[2] = if2.enq_ready;  assign o_dv[2] = if2.deq_valid;  assign o_db[2] = {{(W-8){1'b0}}, if2.deq_bits};
    assign o_er[3] = if3.enq_ready;  assign o_dv[3] = if3.deq_valid;  assign o_db[3] = {{(W-8){1'b0}}, if3.deq_bits};
    assign cnt[0] = cnt0;  assign cnt[1] = cnt1;  assign cnt[2] = cnt2;  assign cnt[3] = cnt3;
    assign af[0]  = af0;   assign af[1]  = af1;   assign af[2]  = af2;   assign af[3]  = af3;

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            ev[i] = 1'b0;
            dr[i] = 1'b0;
            eb[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle_all();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_all();
        ev[3] = 1'b1;
        @(negedge clock);
        #1;
        checks++; if (o_er[0] !== 1'b1) begin failures++; $display("FAIL reset_enq_ready got=%0b exp=1", o_er[0]); end
        checks++; if (o_dv[0] !== 1'b0) begin failures++; $display("FAIL reset_deq_valid got=%0b exp=0", o_dv[0]); end
        checks++; if (cnt[0] !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt[0]); end
        checks++; if (af[0] !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%0b exp=0", af[0]); end
        checks++; if (o_dv[3] !== 1'b1) begin failures++; $display("FAIL reset_flow_deq_valid got=%0b exp=1", o_dv[3]); end
        ev[3] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        checks++; if (o_er[0] !== 1'b1) begin failures++; $display("FAIL release_enq_ready got=%0b exp=1", o_er[0]); end
        checks++; if (o_dv[0] !== 1'b0) begin failures++; $display("FAIL release_deq_valid got=%0b exp=0", o_dv[0]); end
        checks++; if (cnt[0] !== 2'd0) begin failures++; $display("FAIL release_count got=%0d exp=0", cnt[0]); end
    endtask

    task automatic test_fill_drain();
        idle_all();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            ev[1] = 1'b1;
            eb[1] = W'(32'hA + i);
            #1;
            checks++; if (cnt[1] !== 2'(i)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", cnt[1], i); end
            checks++; if (o_er[1] !== 1'b1) begin failures++; $display("FAIL fill_enq_ready got=%0b exp=1", o_er[1]); end
        end
        @(negedge clock);
        ev[1] = 1'b0;
        #1;
        checks++; if (cnt[1] !== 2'd3) begin failures++; $display("FAIL full_count got=%0d exp=3", cnt[1]); end
        checks++; if (o_er[1] !== 1'b0) begin failures++; $display("FAIL full_enq_ready got=%0b exp=0", o_er[1]); end
        checks++; if (af[1] !== 1'b1) begin failures++; $display("FAIL full_almost_full got=%0b exp=1", af[1]); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            dr[1] = 1'b1;
            #1;
            checks++; if (o_dv[1] !== 1'b1) begin failures++; $display("FAIL drain_deq_valid got=%0b exp=1", o_dv[1]); end
            checks++; if (o_db[1] !== W'(32'hA + i)) begin failures++; $display("FAIL drain_data got=%0h exp=%0h", o_db[1], 32'hA + i); end
            checks++; if (cnt[1] !== 2'(3 - i)) begin failures++; $display("FAIL drain_count got=%0d exp=%0d", cnt[1], 3 - i); end
        end
        @(negedge clock);
        dr[1] = 1'b0;
        #1;
        checks++; if (cnt[1] !== 2'd0) begin failures++; $display("FAIL drained_count got=%0d exp=0", cnt[1]); end
        checks++; if (o_dv[1] !== 1'b0) begin failures++; $display("FAIL drained_deq_valid got=%0b exp=0", o_dv[1]); end
    endtask

    task automatic test_wrap();
        int next_in  = 1;
        int next_out = 1;
        int cyc      = 0;
        idle_all();
        while (next_out <= 10 && cyc < 300) begin
            @(negedge clock);
            ev[1] = (next_in <= 10) && ($urandom_range(0, 1) == 1);
            eb[1] = W'(next_in);
            dr[1] = 1'($urandom_range(0, 1));
            #1;
            checks++; if (cnt[1] !== 2'(next_in - next_out)) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", cnt[1], next_in - next_out); end
            checks++; if (o_dv[1] !== (next_in != next_out)) begin failures++; $display("FAIL wrap_deq_valid got=%0b exp=%0b", o_dv[1], next_in != next_out); end
            if (o_dv[1] && dr[1]) begin
                checks++; if (o_db[1] !== W'(next_out)) begin failures++; $display("FAIL wrap_data got=%0h exp=%0h", o_db[1], next_out); end
                next_out++;
            end
            if (ev[1] && o_er[1]) next_in++;
            cyc++;
        end
        checks++; if (next_out != 11) begin failures++; $display("FAIL wrap_timeout got=%0d exp=11", next_out); end
        idle_all();
    endtask

    task automatic test_pipe();
        do_reset();
        @(negedge clock);
        ev[0] = 1'b1;  ev[2] = 1'b1;
        eb[0] = W'(8'h11);  eb[2] = W'(8'h11);
        @(negedge clock);
        eb[0] = W'(8'h22);  eb[2] = W'(8'h22);
        @(negedge clock);
        eb[0] = W'(8'h55);  eb[2] = W'(8'h55);
        dr[0] = 1'b1;  dr[2] = 1'b1;
        #1;
        checks++; if (o_er[2] !== 1'b1) begin failures++; $display("FAIL pipe_enq_ready got=%0b exp=1", o_er[2]); end
        checks++; if (o_db[2] !== W'(8'h11)) begin failures++; $display("FAIL pipe_oldest got=%0h exp=11", o_db[2]); end
        checks++; if (cnt[2] !== 2'd2) begin failures++; $display("FAIL pipe_count got=%0d exp=2", cnt[2]); end
        checks++; if (o_er[0] !== 1'b0) begin failures++; $display("FAIL nopipe_enq_ready got=%0b exp=0", o_er[0]); end
        @(negedge clock);
        ev[0] = 1'b0;  ev[2] = 1'b0;
        #1;
        checks++; if (cnt[2] !== 2'd2) begin failures++; $display("FAIL pipe_count_held got=%0d exp=2", cnt[2]); end
        checks++; if (o_db[2] !== W'(8'h22)) begin failures++; $display("FAIL pipe_second got=%0h exp=22", o_db[2]); end
        checks++; if (cnt[0] !== 2'd1) begin failures++; $display("FAIL nopipe_count got=%0d exp=1", cnt[0]); end
        @(negedge clock);
        #1;
        checks++; if (o_db[2] !== W'(8'h55)) begin failures++; $display("FAIL pipe_replaced got=%0h exp=55", o_db[2]); end
        checks++; if (cnt[2] !== 2'd1) begin failures++; $display("FAIL pipe_count_one got=%0d exp=1", cnt[2]); end
        @(negedge clock);
        dr[0] = 1'b0;  dr[2] = 1'b0;
        #1;
        checks++; if (cnt[2] !== 2'd0) begin failures++; $display("FAIL pipe_empty_count got=%0d exp=0", cnt[2]); end
        checks++; if (o_dv[2] !== 1'b0) begin failures++; $display("FAIL pipe_empty_valid got=%0b exp=0", o_dv[2]); end
    endtask

    task automatic test_flow();
        do_reset();
        @(negedge clock);
        ev[3] = 1'b1;  eb[3] = W'(8'h7F);  dr[3] = 1'b1;
        #1;
        checks++; if (o_dv[3] !== 1'b1) begin failures++; $display("FAIL flow_deq_valid got=%0b exp=1", o_dv[3]); end
        checks++; if (o_db[3] !== W'(8'h7F)) begin failures++; $display("FAIL flow_data got=%0h exp=7f", o_db[3]); end
        checks++; if (cnt[3] !== 2'd0) begin failures++; $display("FAIL flow_count got=%0d exp=0", cnt[3]); end
        @(negedge clock);
        eb[3] = W'(8'h3C);  dr[3] = 1'b0;
        #1;
        checks++; if (cnt[3] !== 2'd0) begin failures++; $display("FAIL flow_not_stored got=%0d exp=0", cnt[3]); end
        checks++; if (o_db[3] !== W'(8'h3C)) begin failures++; $display("FAIL flow_present got=%0h exp=3c", o_db[3]); end
        @(negedge clock);
        ev[3] = 1'b0;
        #1;
        checks++; if (cnt[3] !== 2'd1) begin failures++; $display("FAIL flow_stored_count got=%0d exp=1", cnt[3]); end
        checks++; if (o_db[3] !== W'(8'h3C)) begin failures++; $display("FAIL flow_stored_data got=%0h exp=3c", o_db[3]); end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] v1;
        logic [W-1:0] v2;
        v1 = W'({$urandom(), $urandom(), $urandom(), $urandom()});
        v2 = W'({$urandom(), $urandom(), $urandom(), $urandom()});
        do_reset();
        @(negedge clock);
        ev[0] = 1'b1;  eb[0] = v1;
        @(negedge clock);
        eb[0] = v2;
        @(negedge clock);
        ev[0] = 1'b0;
        #1;
        checks++; if (cnt[0] !== 2'd2) begin failures++; $display("FAIL ar_count_before got=%0d exp=2", cnt[0]); end
        checks++; if (o_db[0] !== v1) begin failures++; $display("FAIL ar_data_before got=%0h exp=%0h", o_db[0], v1); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (o_dv[0] !== 1'b0) begin failures++; $display("FAIL ar_deq_valid got=%0b exp=0", o_dv[0]); end
        checks++; if (cnt[0] !== 2'd0) begin failures++; $display("FAIL ar_count got=%0d exp=0", cnt[0]); end
        checks++; if (o_er[0] !== 1'b1) begin failures++; $display("FAIL ar_enq_ready got=%0b exp=1", o_er[0]); end
        @(negedge clock);
        reset = 1'b1;
        ev[0] = 1'b1;  eb[0] = W'(4'h9);
        @(negedge clock);
        ev[0] = 1'b0;  dr[0] = 1'b1;
        #1;
        checks++; if (o_dv[0] !== 1'b1) begin failures++; $display("FAIL ar_after_valid got=%0b exp=1", o_dv[0]); end
        checks++; if (o_db[0] !== W'(4'h9)) begin failures++; $display("FAIL ar_after_data got=%0h exp=9", o_db[0]); end
        checks++; if (cnt[0] !== 2'd1) begin failures++; $display("FAIL ar_after_count got=%0d exp=1", cnt[0]); end
        @(negedge clock);
        dr[0] = 1'b0;
    endtask

    task automatic test_random();
        int  sz;
        bit  e_er, e_dv, e_af, fire_e, fire_d;
        logic [W-1:0] e_db;
        do_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                if ((cyc / 100) % 2 == 0) begin
                    ev[i] = ($urandom_range(0, 3) != 0);
                    dr[i] = ($urandom_range(0, 2) == 0);
                end else begin
                    ev[i] = ($urandom_range(0, 2) == 0);
                    dr[i] = ($urandom_range(0, 3) != 0);
                end
                if (i == 0) eb[i] = W'({$urandom(), $urandom(), $urandom(), $urandom()});
                else        eb[i] = W'($urandom_range(0, 255));
            end
            #1;
            for (int i = 0; i < N; i++) begin
                sz   = mq[i].size();
                e_er = (sz < depth_c[i]) || (pipe_c[i] && dr[i]);
                e_dv = (sz > 0) || (flow_c[i] && ev[i]);
                e_db = (sz > 0) ? mq[i][0] : eb[i];
                e_af = (sz >= depth_c[i] - 1);
                checks++; if (int'(cnt[i]) != sz) begin failures++; $display("FAIL rnd_count q%0d cyc%0d got=%0d exp=%0d", i, cyc, cnt[i], sz); end
                checks++; if (o_er[i] !== e_er) begin failures++; $display("FAIL rnd_enq_ready q%0d cyc%0d got=%0b exp=%0b", i, cyc, o_er[i], e_er); end
                checks++; if (o_dv[i] !== e_dv) begin failures++; $display("FAIL rnd_deq_valid q%0d cyc%0d got=%0b exp=%0b", i, cyc, o_dv[i], e_dv); end
                checks++; if (af[i] !== e_af) begin failures++; $display("FAIL rnd_almost_full q%0d cyc%0d got=%0b exp=%0b", i, cyc, af[i], e_af); end
                if (e_dv) begin
                    checks++; if (o_db[i] !== e_db) begin failures++; $display("FAIL rnd_data q%0d cyc%0d got=%0h exp=%0h", i, cyc, o_db[i], e_db); end
                end
                fire_d = e_dv && dr[i];
                fire_e = ev[i] && e_er;
                if (!(flow_c[i] && sz == 0 && fire_d)) begin
                    if (fire_d) void'(mq[i].pop_front());
                    if (fire_e) mq[i].push_back(eb[i]);
                end
            end
        end
        idle_all();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_fill_drain();
        test_wrap();
        test_pipe();
        test_flow();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
